// File: rtl/icmp_echo_responder.sv
// icmp_echo_responder: store-and-forward ICMP echo server for the protocol-1 slot.
// Define ICMP_ECHO_CSUM_CHECK_EN to drop requests whose ICMP checksum is wrong.
module icmp_echo_responder #(
  parameter int         BUF_DEPTH = 512,
  parameter logic [7:0] REPLY_TTL = 8'd64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        s_ip_hdr_valid,
  output logic        s_ip_hdr_ready,
  input  logic [15:0] s_ip_length,
  input  logic [31:0] s_ip_source_ip,
  input  logic [31:0] s_ip_dest_ip,
  input  logic [7:0]  s_ip_payload_axis_tdata,
  input  logic        s_ip_payload_axis_tvalid,
  output logic        s_ip_payload_axis_tready,
  input  logic        s_ip_payload_axis_tlast,
  input  logic        s_ip_payload_axis_tuser,
  output logic        m_ip_hdr_valid,
  input  logic        m_ip_hdr_ready,
  output logic [5:0]  m_ip_dscp,
  output logic [1:0]  m_ip_ecn,
  output logic [15:0] m_ip_length,
  output logic [7:0]  m_ip_ttl,
  output logic [7:0]  m_ip_protocol,
  output logic [31:0] m_ip_source_ip,
  output logic [31:0] m_ip_dest_ip,
  output logic [7:0]  m_ip_payload_axis_tdata,
  output logic        m_ip_payload_axis_tvalid,
  input  logic        m_ip_payload_axis_tready,
  output logic        m_ip_payload_axis_tlast,
  output logic        m_ip_payload_axis_tuser,
  output logic [15:0] o_rx_echo_cnt,
  output logic [15:0] o_drop_cnt
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_TWO = (AW+1)'(2);
  localparam logic [AW:0]   CNT_THR = (AW+1)'(3);
  localparam logic [AW:0]   CNT_MIN = (AW+1)'(7);
  localparam logic [AW-1:0] TX_ONE  = AW'(1);
  localparam logic [AW-1:0] TX_TWO  = AW'(2);
  localparam logic [AW-1:0] TX_THR  = AW'(3);

  typedef enum logic [2:0] {
    IDLE, RX, DROP, FINISH, TX_HDR, TX_PAY
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] tx_q, tx_d, rd_addr;
  logic [31:0]   src_q, src_d, dst_q, dst_d;
  logic [7:0]    type_q, type_d, code_q, code_d;
  logic [7:0]    csh_q, csh_d, csl_q, csl_d;
  logic [15:0]   echo_q, echo_d, drop_q, drop_d;
  logic [7:0]    mem_q [BUF_DEPTH];
  logic [7:0]    rd_q;
  logic          we, drop_ev, last_b, csum_ok;
  logic [16:0]   csum_sum;
  logic [15:0]   csum_new;
  logic          unused_len;

  assign unused_len = ^s_ip_length;

`ifdef ICMP_ECHO_CSUM_CHECK_EN
  logic [23:0] acc_q, acc_d;
  logic [16:0] fold1;
  logic [15:0] fold2;
  assign fold1   = {1'b0, acc_q[15:0]} + {9'd0, acc_q[23:16]};
  assign fold2   = fold1[15:0] + {15'd0, fold1[16]};
  assign csum_ok = (fold2 == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  // Type 8 -> 0 raises the checksum by 0x0800 in ones-complement arithmetic.
  assign csum_sum = {1'b0, csh_q, csl_q} + 17'h00800;
  assign csum_new = csum_sum[15:0] + {15'd0, csum_sum[16]};

  assign s_ip_hdr_ready           = (state_q == IDLE) && !i_rst;
  assign s_ip_payload_axis_tready = (state_q == RX) || (state_q == DROP);
  assign m_ip_hdr_valid           = (state_q == TX_HDR);
  assign m_ip_dscp                = '0;
  assign m_ip_ecn                 = '0;
  assign m_ip_length    = m_ip_hdr_valid ? 16'(cnt_q) + 16'd20 : '0;
  assign m_ip_ttl       = m_ip_hdr_valid ? REPLY_TTL : '0;
  assign m_ip_protocol  = m_ip_hdr_valid ? 8'h01 : '0;
  assign m_ip_source_ip = m_ip_hdr_valid ? dst_q : '0;
  assign m_ip_dest_ip   = m_ip_hdr_valid ? src_q : '0;
  assign m_ip_payload_axis_tvalid = (state_q == TX_PAY);
  assign m_ip_payload_axis_tuser  = 1'b0;
  assign last_b = ({1'b0, tx_q} == cnt_q - CNT_ONE);
  assign m_ip_payload_axis_tlast  = m_ip_payload_axis_tvalid && last_b;
  assign o_rx_echo_cnt = echo_q;
  assign o_drop_cnt    = drop_q;

  always_comb begin
    m_ip_payload_axis_tdata = '0;
    if (m_ip_payload_axis_tvalid) begin
      unique case (1'b1)
        (tx_q == '0):     m_ip_payload_axis_tdata = 8'h00;
        (tx_q == TX_TWO): m_ip_payload_axis_tdata = csum_new[15:8];
        (tx_q == TX_THR): m_ip_payload_axis_tdata = csum_new[7:0];
        default:          m_ip_payload_axis_tdata = rd_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    src_d   = src_q;
    dst_d   = dst_q;
    type_d  = type_q;
    code_d  = code_q;
    csh_d   = csh_q;
    csl_d   = csl_q;
    echo_d  = echo_q;
    drop_d  = drop_q;
    drop_ev = 1'b0;
    we      = 1'b0;
    rd_addr = tx_q;
`ifdef ICMP_ECHO_CSUM_CHECK_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      IDLE: if (s_ip_hdr_valid) begin
        src_d   = s_ip_source_ip;
        dst_d   = s_ip_dest_ip;
        cnt_d   = '0;
`ifdef ICMP_ECHO_CSUM_CHECK_EN
        acc_d   = '0;
`endif
        state_d = RX;
      end
      RX: if (s_ip_payload_axis_tvalid) begin
        if (cnt_q[AW]) begin
          drop_ev = 1'b1;
          state_d = s_ip_payload_axis_tlast ? IDLE : DROP;
        end else begin
          we    = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == '0)     type_d = s_ip_payload_axis_tdata;
          if (cnt_q == CNT_ONE) code_d = s_ip_payload_axis_tdata;
          if (cnt_q == CNT_TWO) csh_d  = s_ip_payload_axis_tdata;
          if (cnt_q == CNT_THR) csl_d  = s_ip_payload_axis_tdata;
`ifdef ICMP_ECHO_CSUM_CHECK_EN
          acc_d = acc_q + (cnt_q[0] ? {16'd0, s_ip_payload_axis_tdata}
                                    : {8'd0, s_ip_payload_axis_tdata, 8'd0});
`endif
          if (s_ip_payload_axis_tlast) begin
            if (!s_ip_payload_axis_tuser && cnt_q >= CNT_MIN &&
                type_q == 8'd8 && code_q == 8'd0) begin
              state_d = FINISH;
            end else begin
              drop_ev = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      DROP: if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
        state_d = IDLE;
      end
      FINISH: begin
        if (csum_ok) begin
          state_d = TX_HDR;
        end else begin
          drop_ev = 1'b1;
          state_d = IDLE;
        end
      end
      TX_HDR: begin
        rd_addr = '0;
        if (m_ip_hdr_ready) begin
          if (echo_q != 16'hFFFF) echo_d = echo_q + 16'd1;
          tx_d    = '0;
          state_d = TX_PAY;
        end
      end
      TX_PAY: if (m_ip_payload_axis_tready) begin
        // Fetch the next byte on a handshake so the stream never bubbles.
        rd_addr = tx_q + TX_ONE;
        tx_d    = tx_q + TX_ONE;
        if (last_b) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (drop_ev && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (we) mem_q[cnt_q[AW-1:0]] <= s_ip_payload_axis_tdata;
    rd_q <= mem_q[rd_addr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      type_q  <= '0;
      code_q  <= '0;
      csh_q   <= '0;
      csl_q   <= '0;
      echo_q  <= '0;
      drop_q  <= '0;
`ifdef ICMP_ECHO_CSUM_CHECK_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      type_q  <= type_d;
      code_q  <= code_d;
      csh_q   <= csh_d;
      csl_q   <= csl_d;
      echo_q  <= echo_d;
      drop_q  <= drop_d;
`ifdef ICMP_ECHO_CSUM_CHECK_EN
      acc_q   <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_icmp_echo_responder.sv
// Bench for icmp_echo_responder: random and directed packets checked
// against a packet-level reply model rebuilt from the observed rx stream.
module tb_icmp_echo_responder;
  localparam int BD = 512;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        s_hdr_valid = 1'b0;
  logic        s_hdr_ready;
  logic [15:0] s_len = '0;
  logic [31:0] s_src = '0;
  logic [31:0] s_dst = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        m_hdr_valid;
  logic        m_hdr_ready = 1'b1;
  logic [5:0]  m_dscp;
  logic [1:0]  m_ecn;
  logic [15:0] m_len;
  logic [7:0]  m_ttl;
  logic [7:0]  m_proto;
  logic [31:0] m_src;
  logic [31:0] m_dst;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        m_tuser;
  logic [15:0] echo_cnt;
  logic [15:0] drop_cnt;

  icmp_echo_responder #(.BUF_DEPTH(BD), .REPLY_TTL(8'd64)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_ip_hdr_valid(s_hdr_valid), .s_ip_hdr_ready(s_hdr_ready),
    .s_ip_length(s_len), .s_ip_source_ip(s_src), .s_ip_dest_ip(s_dst),
    .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tvalid(s_tvalid),
    .s_ip_payload_axis_tready(s_tready), .s_ip_payload_axis_tlast(s_tlast),
    .s_ip_payload_axis_tuser(s_tuser),
    .m_ip_hdr_valid(m_hdr_valid), .m_ip_hdr_ready(m_hdr_ready),
    .m_ip_dscp(m_dscp), .m_ip_ecn(m_ecn), .m_ip_length(m_len),
    .m_ip_ttl(m_ttl), .m_ip_protocol(m_proto),
    .m_ip_source_ip(m_src), .m_ip_dest_ip(m_dst),
    .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tvalid(m_tvalid),
    .m_ip_payload_axis_tready(m_tready), .m_ip_payload_axis_tlast(m_tlast),
    .m_ip_payload_axis_tuser(m_tuser),
    .o_rx_echo_cnt(echo_cnt), .o_drop_cnt(drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired t=%0t", name, $time);
  endtask

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } hdr_t;

  hdr_t       exp_hdr_q[$];
  logic [7:0] exp_pay_q[$];
  logic [7:0] rx_b[$];
  logic [31:0] rx_src, rx_dst;
  bit         hdr_done, pstall, hstall;
  int         pidx, lat, exp_echo, exp_drop;
  logic [7:0] pst_data;
  logic       pst_last;
  hdr_t       hst, fr;
  logic [7:0] eb;
  int         cs, n;
  bit         ok;

  logic [31:0] cap_src, cap_dst;
  logic [15:0] cap_len;
  logic [7:0]  cap_ttl, cap_proto, cap_b0, cap_b2, cap_b3;
  int          cap_n = 0;

  // Model: decide eligibility from the whole received packet and build its reply.
  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_hdr_q.delete();
      exp_pay_q.delete();
      rx_b.delete();
      hdr_done = 0; pstall = 0; hstall = 0; lat = 0;
      exp_echo = 0; exp_drop = 0;
      chk("rst_s_hdr_ready", s_hdr_ready, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_hdr_valid", m_hdr_valid, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_len", m_len, 0);
      chk("rst_echo_cnt", echo_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
    end else begin
      if (lat > 0) begin
        lat--;
        chk("hdr_latency", m_hdr_valid, lat == 0);
      end
      if (exp_hdr_q.size() != 0) begin
        chk("s_hdr_ready_busy", s_hdr_ready, 0);
        chk("s_tready_busy", s_tready, 0);
      end
      if (exp_hdr_q.size() == 0 || hdr_done)
        chk("no_hdr_valid", m_hdr_valid, 0);
      if (!hdr_done)
        chk("no_pay_valid", m_tvalid, 0);
      if (hstall) begin
        chk("hdr_hold_valid", m_hdr_valid, 1);
        chk("hdr_hold_len", m_len, hst.len);
        chk("hdr_hold_dst", m_dst, hst.dst);
      end
      if (pstall) begin
        chk("pay_hold_valid", m_tvalid, 1);
        chk("pay_hold_data", m_tdata, pst_data);
        chk("pay_hold_last", m_tlast, pst_last);
      end
      hstall = m_hdr_valid && !m_hdr_ready;
      hst = '{src: m_src, dst: m_dst, len: m_len};
      pstall = m_tvalid && !m_tready;
      pst_data = m_tdata;
      pst_last = m_tlast;
      if (m_hdr_valid && m_hdr_ready && !hdr_done && exp_hdr_q.size() != 0) begin
        fr = exp_hdr_q[0];
        chk("hdr_src", m_src, fr.src);
        chk("hdr_dst", m_dst, fr.dst);
        chk("hdr_len", m_len, fr.len);
        chk("hdr_ttl", m_ttl, 8'd64);
        chk("hdr_proto", m_proto, 8'd1);
        chk("hdr_dscp", m_dscp, 0);
        chk("hdr_ecn", m_ecn, 0);
        cap_src = m_src; cap_dst = m_dst; cap_len = m_len;
        cap_ttl = m_ttl; cap_proto = m_proto;
        hdr_done = 1;
        pidx = 0;
        if (exp_echo < 65535) exp_echo++;
      end
      if (m_tvalid && m_tready && hdr_done) begin
        fr = exp_hdr_q[0];
        eb = exp_pay_q.pop_front();
        chk("pay_data", m_tdata, eb);
        chk("pay_last", m_tlast, pidx == int'(fr.len) - 21);
        chk("pay_tuser", m_tuser, 0);
        if (pidx == 0) cap_b0 = m_tdata;
        if (pidx == 2) cap_b2 = m_tdata;
        if (pidx == 3) cap_b3 = m_tdata;
        pidx++;
        cap_n = pidx;
        if (pidx == int'(fr.len) - 20) begin
          void'(exp_hdr_q.pop_front());
          hdr_done = 0;
        end
      end
      if (s_hdr_valid && s_hdr_ready) begin
        rx_src = s_src;
        rx_dst = s_dst;
        rx_b.delete();
      end
      if (s_tvalid && s_tready) begin
        rx_b.push_back(s_tdata);
        if (s_tlast) begin
          n = rx_b.size();
          ok = !s_tuser && n >= 8 && n <= BD && rx_b[0] == 8'd8 && rx_b[1] == 8'd0;
          if (ok) begin
            exp_hdr_q.push_back('{src: rx_dst, dst: rx_src, len: 16'(20 + n)});
            cs = {rx_b[2], rx_b[3]} + 'h800;
            if (cs > 'hFFFF) cs = cs - 'hFFFF;
            for (int i = 0; i < n; i++) begin
              if (i == 0)      exp_pay_q.push_back(8'h00);
              else if (i == 2) exp_pay_q.push_back(8'(cs >> 8));
              else if (i == 3) exp_pay_q.push_back(8'(cs));
              else             exp_pay_q.push_back(rx_b[i]);
            end
            lat = 2;
          end else if (exp_drop < 65535) begin
            exp_drop++;
          end
        end
      end
    end
  end

  int mmode = 0;
  int hold = 0;
  always @(posedge i_clk) begin
    #1;
    if (mmode == 0) begin
      m_hdr_ready = 1'b1;
      m_tready = 1'b1;
    end else if (mmode == 1) begin
      m_hdr_ready = 1'($urandom_range(0, 1));
      m_tready = ($urandom_range(0, 3) != 0);
    end else begin
      if (m_hdr_valid && hold < 10) begin
        hold++;
        m_hdr_ready = 1'b0;
      end else begin
        m_hdr_ready = (hold >= 10);
      end
      m_tready = ~m_tready;
    end
  end

  logic [7:0] pkt[$];

  task automatic build(input int len, input logic [7:0] ty,
                       input logic [7:0] cd, input logic [15:0] cs_in);
    pkt.delete();
    for (int i = 0; i < len; i++) begin
      if (i == 0)      pkt.push_back(ty);
      else if (i == 1) pkt.push_back(cd);
      else if (i == 2) pkt.push_back(cs_in[15:8]);
      else if (i == 3) pkt.push_back(cs_in[7:0]);
      else             pkt.push_back(8'($urandom));
    end
  endtask

  task automatic send(input logic [31:0] src, input logic [31:0] dst,
                      input bit bad, input bit gaps, input int abort_at);
    bit got;
    s_hdr_valid = 1'b1;
    s_src = src;
    s_dst = dst;
    s_len = 16'(20 + pkt.size());
    got = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge i_clk);
      if (s_hdr_ready) begin got = 1; break; end
    end
    @(posedge i_clk); #1;
    s_hdr_valid = 1'b0;
    if (!got) begin fail_bound("s_hdr_wait"); return; end
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == abort_at) begin
        s_tvalid = 1'b0;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge i_clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata = pkt[i];
      s_tlast = (i == pkt.size() - 1);
      s_tuser = bad && (i == pkt.size() - 1);
      got = 0;
      for (int t = 0; t < 4000; t++) begin
        @(negedge i_clk);
        if (s_tready) begin got = 1; break; end
      end
      @(posedge i_clk); #1;
      if (!got) begin
        fail_bound("s_byte_wait");
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int t = 0; t < 6000; t++) begin
      @(negedge i_clk);
      if (exp_hdr_q.size() == 0 && s_hdr_ready && !m_hdr_valid && !m_tvalid) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_bound("idle_wait");
    chk("echo_cnt_model", echo_cnt, exp_echo);
    chk("drop_cnt_model", drop_cnt, exp_drop);
    @(posedge i_clk); #1;
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int r;
  initial begin
    #1 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    build(64, 8'd8, 8'd0, 16'h1234);
    cap_n = 0;
    send(32'hAC00000A, 32'hAC000002, 0, 0, -1);
    wait_idle();
    chk("t1_dst", cap_dst, 32'hAC00000A);
    chk("t1_src", cap_src, 32'hAC000002);
    chk("t1_len", cap_len, 84);
    chk("t1_ttl", cap_ttl, 64);
    chk("t1_proto", cap_proto, 1);
    chk("t1_nbytes", cap_n, 64);
    chk("t1_b0", cap_b0, 8'h00);
    chk("t1_csum_hi", cap_b2, 8'h1A);
    chk("t1_csum_lo", cap_b3, 8'h34);
    chk("t1_echo", echo_cnt, 1);

    build(20, 8'd8, 8'd0, 16'hF900);
    send(32'h0A000001, 32'h0A000002, 0, 1, -1);
    wait_idle();
    chk("t2_csum_hi", cap_b2, 8'h01);
    chk("t2_csum_lo", cap_b3, 8'h01);

    build(16, 8'd0, 8'd0, 16'h5555);
    send(32'h01020304, 32'h05060708, 0, 0, -1);
    wait_idle();
    build(7, 8'd8, 8'd0, 16'h0000);
    send(32'h01020304, 32'h05060708, 0, 0, -1);
    wait_idle();
    build(64, 8'd8, 8'd0, 16'h1111);
    send(32'h01020304, 32'h05060708, 1, 0, -1);
    wait_idle();
    chk("t3_drops", drop_cnt, 3);
    chk("t3_echo_held", echo_cnt, 2);
    build(8, 8'd8, 8'd0, 16'hABCD);
    send(32'h11111111, 32'h22222222, 0, 0, -1);
    wait_idle();
    chk("t3_next_echo", echo_cnt, 3);

    build(600, 8'd8, 8'd0, 16'h0001);
    send(32'h33333333, 32'h44444444, 0, 0, -1);
    wait_idle();
    chk("t4_overflow_drop", drop_cnt, 4);
    chk("t4_overflow_echo", echo_cnt, 3);

    mmode = 1;
    build(BD, 8'd8, 8'd0, 16'h7FFF);
    send(32'h55555555, 32'h66666666, 0, 1, -1);
    wait_idle();
    chk("t4_full_echo", echo_cnt, 4);
    build(BD + 1, 8'd8, 8'd0, 16'h7FFF);
    send(32'h55555555, 32'h66666666, 0, 0, -1);
    wait_idle();
    chk("t4_full1_drop", drop_cnt, 5);

    hold = 0;
    mmode = 2;
    build(64, 8'd8, 8'd0, 16'h2468);
    send(32'h77777777, 32'h88888888, 0, 0, -1);
    wait_idle();
    chk("t5_bp_echo", echo_cnt, 5);
    chk("t5_bp_nbytes", cap_n, 64);

    mmode = 1;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      build($urandom_range(8, 40), 8'd0, 8'd0, 16'($urandom));
      else if (r == 1) build($urandom_range(1, 7), 8'd8, 8'd0, 16'($urandom));
      else if (r == 2) build($urandom_range(8, 40), 8'd8, 8'($urandom_range(1, 255)), 16'($urandom));
      else             build($urandom_range(8, 90), 8'd8, 8'd0, 16'($urandom));
      send($urandom, $urandom, r == 3, 1, -1);
      wait_idle();
    end

    mmode = 0;
    build(64, 8'd8, 8'd0, 16'h1234);
    send(32'hAC00000A, 32'hAC000002, 0, 0, 20);
    wait_idle();
    chk("t6_echo_zero", echo_cnt, 0);
    chk("t6_drop_zero", drop_cnt, 0);
    build(64, 8'd8, 8'd0, 16'h1234);
    send(32'hAC00000B, 32'hAC000003, 0, 0, -1);
    wait_idle();
    chk("t6_echo_one", echo_cnt, 1);
    chk("t6_fresh_dst", cap_dst, 32'hAC00000B);
    chk("t6_fresh_csum_hi", cap_b2, 8'h1A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icmp_echo_responder.md
Name: icmp_echo_responder

Overview:
- Store-and-forward ICMP echo server for the network processor's ICMP protocol slot.
- Consumes IP packets that the IP demux has steered to the ICMP index (protocol 1).
- For each valid echo request, emits an echo reply toward the IP arbitration mux.
- All other ICMP traffic, and any malformed packet, is consumed silently.

Parameters:
- BUF_DEPTH, 512: ICMP message buffer size in bytes (power of 2, ≥ 8). Address width is clog2(BUF_DEPTH).
- REPLY_TTL, 8'd64: TTL placed on every reply.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- s_ip_hdr_valid / s_ip_hdr_ready  in / out  1 / 1  rx header handshake
- s_ip_length  in  16  rx IP total length (informational; not trusted)
- s_ip_source_ip / s_ip_dest_ip  in  32 / 32  rx addresses
- s_ip_payload_axis_tdata  in  8  rx ICMP bytes
- s_ip_payload_axis_tvalid / tready / tlast / tuser  in / out / in / in  1 each  rx payload stream (tuser=1 on tlast means bad frame)
- m_ip_hdr_valid / m_ip_hdr_ready  out / in  1 / 1  tx header handshake
- m_ip_dscp / m_ip_ecn  out  6 / 2  constant 0
- m_ip_length  out  16  20 + stored byte count
- m_ip_ttl / m_ip_protocol  out  8 / 8  REPLY_TTL / 8'h01
- m_ip_source_ip / m_ip_dest_ip  out  32 / 32  rx dest_ip / rx source_ip
- m_ip_payload_axis_tdata  out  8  reply bytes
- m_ip_payload_axis_tvalid / tready / tlast / tuser  out / in / out / out  1 each  tuser is constant 0
- o_rx_echo_cnt / o_drop_cnt  out  16 / 16  saturating counters

Behaviour:
- Reset values: all outputs 0, all counters 0, state IDLE.
- Reset is asynchronous and may occur mid-packet. The partial packet is discarded and no tx valid glitches high.
- Interface rule: one packet in flight; no rx acceptance while a reply is outstanding.
- States:
  - IDLE: s_ip_hdr_ready=1. On hdr handshake, latch src/dst IP, clear byte count, go RX.
  - RX: payload tready=1. Each accepted byte is written at buf[count] and count increments. Bytes 0/1/2/3 (type/code/csum_hi/csum_lo) are also latched.
    - Accepting byte index BUF_DEPTH (overflow) → count drop, go DROP (tlast on that byte → IDLE).
    - On tlast, → FINISH if tuser=0, count ≥ 8, type=8 and code=0. Otherwise count a drop and go IDLE.
  - DROP: tready=1, discard bytes until tlast, then IDLE.
  - FINISH: exactly one cycle, used for checksum fold. → TX_HDR, or → IDLE with a drop if the optional check fails.
  - TX_HDR: m_ip_hdr_valid=1 with fields stable until m_ip_hdr_ready. On handshake, increment o_rx_echo_cnt, → TX_PAY.
  - TX_PAY: stream buf[0..count-1].
    - Byte 0 is replaced with 8'h00.
    - Bytes 2–3 are replaced with the new checksum C' = csum + 16'h0800 with end-around carry: a 17-bit sum whose bit 16 is added back into the low 16 bits.
    - tlast on byte count-1.
    - Data is held stable while tvalid=1 and tready=0; buffer RAM read latency is hidden by prefetch, with no bubbles under continuous tready.
    - After the last handshake → IDLE.
- Latency: m_ip_hdr_valid rises exactly 2 cycles after the rx tlast handshake.
- Counters saturate at 16'hFFFF.
- No combinational path from m_* ready inputs to s_* ready outputs.

Optional Feature:
- Macro: ICMP_ECHO_CSUM_CHECK_EN.
- Defined:
  - RX accumulates a 16-bit ones-complement sum of all ICMP bytes as big-endian words. An odd final byte is padded low with 0.
  - FINISH folds the sum and requires it to equal 16'hFFFF.
  - A mismatch counts a drop and returns to IDLE with no reply.
- Undefined: no checksum verification; the accumulator logic is absent.

Test Plan:
- Echo request, 64 bytes (type 8, code 0, csum 0x1234, 56 data bytes), src 0xAC00000A, dst 0xAC000002 → one reply:
  - header: dst 0xAC00000A, src 0xAC000002, length 84, ttl 64, proto 1
  - payload: 64 bytes, byte0 0x00, csum bytes 0x1A 0x34, bytes 4–63 identical to request
  - o_rx_echo_cnt=1
- Checksum carry: request csum 0xF900 → reply csum 0x0101.
- Non-echo and bad frames, each sent separately → no m_ip_hdr_valid, o_drop_cnt=3, and the next valid echo still answered:
  - type 0 reply packet
  - 7-byte runt
  - request with tuser=1 on tlast
- Overflow: 600-byte request with BUF_DEPTH=512 → all 600 bytes accepted, no reply, drop count +1.
- Backpressure: m_ip_hdr_ready held 0 for 10 cycles, then m tready toggling 1/0 every cycle → s_ip_hdr_ready stays 0 until reply completes; tx data stable under stall; byte sequence exact.
- Reset mid-RX (byte 20 of 64) then a fresh echo → no stale reply; fresh reply correct; counters 0 then 1.
